// File: rtl/mem_init_loader_if.sv
// Stream-in / debug-port bundle between the image loader and the core.
// The loader is the master: it sinks the word stream and drives both memory debug ports.
interface mem_init_loader_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    logic                  in_valid;
    logic [DATA_W-1:0]     in_data;
    logic                  in_ready;

    logic                  enable_debug;
    logic [DM_ADDRESS-1:0] debug_inst_addr;
    logic [DATA_W-1:0]     debug_inst_data1;
    logic [DATA_W-1:0]     debug_inst_data2;
    logic [DM_ADDRESS-1:0] DebugAddress;
    logic [DATA_W-1:0]     DebugData1;
    logic [DATA_W-1:0]     DebugData2;

    modport master (
        input  in_valid, in_data,
        output in_ready, enable_debug,
        output debug_inst_addr, debug_inst_data1, debug_inst_data2,
        output DebugAddress, DebugData1, DebugData2
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, enable_debug,
        input  debug_inst_addr, debug_inst_data1, debug_inst_data2,
        input  DebugAddress, DebugData1, DebugData2
    );
endinterface

// File: rtl/mem_init_loader.sv
// Loads instruction then data memory through the core's debug ports in 64-bit pairs,
// then drops enable_debug so the core starts from the loaded image.
module mem_init_loader #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 7,
    parameter int SETTLE_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  inst_pairs,
    input  logic [CNT_W-1:0]  data_pairs,
    mem_init_loader_if.master bus,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE, INST_LO, INST_HI, DATA_LO, DATA_HI, SETTLE, DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      inst_cnt_q, inst_cnt_d;
    logic [CNT_W-1:0]      data_cnt_q, data_cnt_d;
    logic [CNT_W-1:0]      inst_idx_q, inst_idx_d;
    logic [CNT_W-1:0]      data_idx_q, data_idx_d;
    logic [DATA_W-1:0]     lo_word_q, lo_word_d;
    logic [3:0]            settle_cnt_q, settle_cnt_d;
    logic                  enable_debug_q, enable_debug_d;
    logic                  in_ready_q, in_ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [DM_ADDRESS-1:0] inst_addr_q, inst_addr_d;
    logic [DATA_W-1:0]     inst_d1_q, inst_d1_d;
    logic [DATA_W-1:0]     inst_d2_q, inst_d2_d;
    logic [DM_ADDRESS-1:0] dm_addr_q, dm_addr_d;
    logic [DATA_W-1:0]     dm_d1_q, dm_d1_d;
    logic [DATA_W-1:0]     dm_d2_q, dm_d2_d;

    logic                  accept;
    logic [CNT_W-1:0]      inst_idx_inc;
    logic [CNT_W-1:0]      data_idx_inc;

    // Byte address of a pair; wraps modulo the port's address range.
    function automatic logic [DM_ADDRESS-1:0] pair_addr(input logic [CNT_W-1:0] idx);
        return DM_ADDRESS'({idx, 3'b000});
    endfunction

    assign accept       = bus.in_valid && in_ready_q;
    assign inst_idx_inc = inst_idx_q + CNT_W'(1);
    assign data_idx_inc = data_idx_q + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        inst_cnt_d   = inst_cnt_q;
        data_cnt_d   = data_cnt_q;
        inst_idx_d   = inst_idx_q;
        data_idx_d   = data_idx_q;
        lo_word_d    = lo_word_q;
        settle_cnt_d = '0;
        inst_addr_d  = inst_addr_q;
        inst_d1_d    = inst_d1_q;
        inst_d2_d    = inst_d2_q;
        dm_addr_d    = dm_addr_q;
        dm_d1_d      = dm_d1_q;
        dm_d2_d      = dm_d2_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    inst_cnt_d = inst_pairs;
                    data_cnt_d = data_pairs;
                    inst_idx_d = '0;
                    data_idx_d = '0;
                    if (inst_pairs != '0)      state_d = INST_LO;
                    else if (data_pairs != '0) state_d = DATA_LO;
                    else                       state_d = SETTLE;
                end
            end
            INST_LO: begin
                if (accept) begin
                    lo_word_d = bus.in_data;
                    state_d   = INST_HI;
                end
            end
            INST_HI: begin
                // Address and both words move together so the memory never sees a torn pair.
                if (accept) begin
                    inst_addr_d = pair_addr(inst_idx_q);
                    inst_d1_d   = lo_word_q;
                    inst_d2_d   = bus.in_data;
                    inst_idx_d  = inst_idx_inc;
                    if (inst_idx_inc != inst_cnt_q) state_d = INST_LO;
                    else if (data_cnt_q != '0)      state_d = DATA_LO;
                    else                            state_d = SETTLE;
                end
            end
            DATA_LO: begin
                if (accept) begin
                    lo_word_d = bus.in_data;
                    state_d   = DATA_HI;
                end
            end
            DATA_HI: begin
                if (accept) begin
                    dm_addr_d  = pair_addr(data_idx_q);
                    dm_d1_d    = lo_word_q;
                    dm_d2_d    = bus.in_data;
                    data_idx_d = data_idx_inc;
                    state_d    = (data_idx_inc == data_cnt_q) ? SETTLE : DATA_LO;
                end
            end
            SETTLE: begin
                if (settle_cnt_q == 4'(SETTLE_CYC)) state_d = DONE;
                else settle_cnt_d = settle_cnt_q + 4'd1;
            end
            default: state_d = IDLE;
        endcase

        // Status outputs are registered from the next state so they line up with it.
        enable_debug_d = !(state_d inside {IDLE, DONE});
        busy_d         = !(state_d inside {IDLE, DONE});
        in_ready_d     = state_d inside {INST_LO, INST_HI, DATA_LO, DATA_HI};
        done_d         = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            inst_cnt_q     <= '0;
            data_cnt_q     <= '0;
            inst_idx_q     <= '0;
            data_idx_q     <= '0;
            lo_word_q      <= '0;
            settle_cnt_q   <= '0;
            enable_debug_q <= 1'b0;
            in_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            inst_addr_q    <= '0;
            inst_d1_q      <= '0;
            inst_d2_q      <= '0;
            dm_addr_q      <= '0;
            dm_d1_q        <= '0;
            dm_d2_q        <= '0;
        end else begin
            state_q        <= state_d;
            inst_cnt_q     <= inst_cnt_d;
            data_cnt_q     <= data_cnt_d;
            inst_idx_q     <= inst_idx_d;
            data_idx_q     <= data_idx_d;
            lo_word_q      <= lo_word_d;
            settle_cnt_q   <= settle_cnt_d;
            enable_debug_q <= enable_debug_d;
            in_ready_q     <= in_ready_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            inst_addr_q    <= inst_addr_d;
            inst_d1_q      <= inst_d1_d;
            inst_d2_q      <= inst_d2_d;
            dm_addr_q      <= dm_addr_d;
            dm_d1_q        <= dm_d1_d;
            dm_d2_q        <= dm_d2_d;
        end
    end

    assign bus.in_ready         = in_ready_q;
    assign bus.enable_debug     = enable_debug_q;
    assign bus.debug_inst_addr  = inst_addr_q;
    assign bus.debug_inst_data1 = inst_d1_q;
    assign bus.debug_inst_data2 = inst_d2_q;
    assign bus.DebugAddress     = dm_addr_q;
    assign bus.DebugData1       = dm_d1_q;
    assign bus.DebugData2       = dm_d2_q;
    assign busy                 = busy_q;
    assign done                 = done_q;

endmodule

// File: tb/tb_mem_init_loader.sv
// Directed bench for mem_init_loader: each scenario task drives stimulus and
// compares the debug ports and status flags against hand-computed values.
module tb_mem_init_loader;
    localparam int DM_ADDRESS = 9;
    localparam int DATA_W     = 32;
    localparam int CNT_W      = 7;
    localparam int SETTLE_CYC = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] inst_pairs;
    logic [CNT_W-1:0] data_pairs;
    logic             busy;
    logic             done;

    int vectors     = 0;
    int miscompares = 0;

    mem_init_loader_if #(.DM_ADDRESS(DM_ADDRESS), .DATA_W(DATA_W)) bus ();

    mem_init_loader #(
        .DM_ADDRESS(DM_ADDRESS), .DATA_W(DATA_W), .CNT_W(CNT_W), .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .inst_pairs(inst_pairs), .data_pairs(data_pairs),
        .bus(bus), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [CNT_W-1:0] ni, input logic [CNT_W-1:0] nd);
        inst_pairs = ni;
        data_pairs = nd;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic send(input logic [DATA_W-1:0] w);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; inst_pairs = '0; data_pairs = '0;
        bus.in_valid = 1'b0; bus.in_data = '0;
        tick(); tick();
        reset = 1'b0;
        vectors++;
        if ({bus.enable_debug, bus.in_ready, busy, done} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got en/rdy/busy/done=%b%b%b%b want 0000",
                     bus.enable_debug, bus.in_ready, busy, done);
        end
        vectors++;
        if ({bus.debug_inst_addr, bus.debug_inst_data1, bus.debug_inst_data2,
             bus.DebugAddress, bus.DebugData1, bus.DebugData2} !== '0) begin
            miscompares++;
            $display("FAIL reset_ports: got inst %h/%h/%h data %h/%h/%h want all 0",
                     bus.debug_inst_addr, bus.debug_inst_data1, bus.debug_inst_data2,
                     bus.DebugAddress, bus.DebugData1, bus.DebugData2);
        end
    endtask

    task automatic test_back_to_back();
        do_start(7'd2, 7'd1);
        vectors++;
        if ({bus.enable_debug, busy, bus.in_ready, done} !== 4'b1110) begin
            miscompares++;
            $display("FAIL b2b_start_flags: got en/busy/rdy/done=%b%b%b%b want 1110",
                     bus.enable_debug, busy, bus.in_ready, done);
        end
        send(32'h11);
        vectors++;
        if ({bus.debug_inst_addr, bus.debug_inst_data1, bus.debug_inst_data2} !== '0) begin
            miscompares++;
            $display("FAIL b2b_half_pair: got %h/%h/%h want 000/0/0",
                     bus.debug_inst_addr, bus.debug_inst_data1, bus.debug_inst_data2);
        end
        send(32'h22);
        vectors++;
        if (bus.debug_inst_addr !== 9'h000 || bus.debug_inst_data1 !== 32'h11 ||
            bus.debug_inst_data2 !== 32'h22) begin
            miscompares++;
            $display("FAIL b2b_inst_pair0: got %h/%h/%h want 000/11/22",
                     bus.debug_inst_addr, bus.debug_inst_data1, bus.debug_inst_data2);
        end
        vectors++;
        if ({bus.DebugAddress, bus.DebugData1, bus.DebugData2} !== '0) begin
            miscompares++;
            $display("FAIL b2b_data_idle: got %h/%h/%h want 000/0/0",
                     bus.DebugAddress, bus.DebugData1, bus.DebugData2);
        end
        send(32'h33);
        send(32'h44);
        vectors++;
        if (bus.debug_inst_addr !== 9'h008 || bus.debug_inst_data1 !== 32'h33 ||
            bus.debug_inst_data2 !== 32'h44) begin
            miscompares++;
            $display("FAIL b2b_inst_pair1: got %h/%h/%h want 008/33/44",
                     bus.debug_inst_addr, bus.debug_inst_data1, bus.debug_inst_data2);
        end
        send(32'h55);
        send(32'h66);
        vectors++;
        if (bus.DebugAddress !== 9'h000 || bus.DebugData1 !== 32'h55 ||
            bus.DebugData2 !== 32'h66) begin
            miscompares++;
            $display("FAIL b2b_data_pair0: got %h/%h/%h want 000/55/66",
                     bus.DebugAddress, bus.DebugData1, bus.DebugData2);
        end
        vectors++;
        if ({bus.enable_debug, bus.in_ready, done} !== 3'b100) begin
            miscompares++;
            $display("FAIL b2b_settle_entry: got en/rdy/done=%b%b%b want 100",
                     bus.enable_debug, bus.in_ready, done);
        end
        tick(); tick();
        vectors++;
        if ({bus.enable_debug, done} !== 2'b10) begin
            miscompares++;
            $display("FAIL b2b_settle_hold: got en/done=%b%b want 10", bus.enable_debug, done);
        end
        tick();
        vectors++;
        if ({bus.enable_debug, busy, done} !== 3'b001) begin
            miscompares++;
            $display("FAIL b2b_release: got en/busy/done=%b%b%b want 001",
                     bus.enable_debug, busy, done);
        end
        vectors++;
        if (bus.debug_inst_addr !== 9'h008 || bus.debug_inst_data2 !== 32'h44 ||
            bus.DebugData2 !== 32'h66) begin
            miscompares++;
            $display("FAIL b2b_done_hold: got inst %h/%h data2 %h want 008/44 data2 66",
                     bus.debug_inst_addr, bus.debug_inst_data2, bus.DebugData2);
        end
    endtask

    task automatic test_stall();
        logic [DATA_W-1:0]     words [6] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};
        logic [DM_ADDRESS-1:0] e_ia = 9'h008;
        logic [DATA_W-1:0]     e_i1 = 32'h33, e_i2 = 32'h44;
        logic [DM_ADDRESS-1:0] e_da = 9'h000;
        logic [DATA_W-1:0]     e_d1 = 32'h55, e_d2 = 32'h66;
        do_start(7'd2, 7'd1);
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 32'hDEAD_BEEF;
            tick();
            vectors++;
            if (bus.debug_inst_addr !== e_ia || bus.debug_inst_data1 !== e_i1 ||
                bus.debug_inst_data2 !== e_i2 || bus.DebugAddress !== e_da ||
                bus.DebugData1 !== e_d1 || bus.DebugData2 !== e_d2 || bus.in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got inst %h/%h/%h data %h/%h/%h rdy %b want %h/%h/%h %h/%h/%h rdy 1",
                         i, bus.debug_inst_addr, bus.debug_inst_data1, bus.debug_inst_data2,
                         bus.DebugAddress, bus.DebugData1, bus.DebugData2, bus.in_ready,
                         e_ia, e_i1, e_i2, e_da, e_d1, e_d2);
            end
            send(words[i]);
            if (i == 1) begin e_ia = 9'h000; e_i1 = 32'h11; e_i2 = 32'h22; end
            if (i == 3) begin e_ia = 9'h008; e_i1 = 32'h33; e_i2 = 32'h44; end
            if (i == 5) begin e_da = 9'h000; e_d1 = 32'h55; e_d2 = 32'h66; end
            vectors++;
            if (bus.debug_inst_addr !== e_ia || bus.debug_inst_data1 !== e_i1 ||
                bus.debug_inst_data2 !== e_i2 || bus.DebugAddress !== e_da ||
                bus.DebugData1 !== e_d1 || bus.DebugData2 !== e_d2) begin
                miscompares++;
                $display("FAIL stall_accept[%0d]: got inst %h/%h/%h data %h/%h/%h want %h/%h/%h %h/%h/%h",
                         i, bus.debug_inst_addr, bus.debug_inst_data1, bus.debug_inst_data2,
                         bus.DebugAddress, bus.DebugData1, bus.DebugData2,
                         e_ia, e_i1, e_i2, e_da, e_d1, e_d2);
            end
        end
        tick(); tick(); tick();
        vectors++;
        if ({bus.enable_debug, done} !== 2'b01) begin
            miscompares++;
            $display("FAIL stall_release: got en/done=%b%b want 01", bus.enable_debug, done);
        end
    endtask

    task automatic test_zero_counts();
        do_start(7'd0, 7'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h77;
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if ({bus.in_ready, bus.enable_debug, busy, done} !== 4'b0110) begin
                miscompares++;
                $display("FAIL zero_settle[%0d]: got rdy/en/busy/done=%b%b%b%b want 0110",
                         c, bus.in_ready, bus.enable_debug, busy, done);
            end
            if (c < 2) tick();
        end
        tick();
        vectors++;
        if ({bus.in_ready, bus.enable_debug, busy, done} !== 4'b0001) begin
            miscompares++;
            $display("FAIL zero_done: got rdy/en/busy/done=%b%b%b%b want 0001",
                     bus.in_ready, bus.enable_debug, busy, done);
        end
        vectors++;
        if (bus.debug_inst_addr !== 9'h008 || bus.debug_inst_data1 !== 32'h33) begin
            miscompares++;
            $display("FAIL zero_no_consume: got inst %h/%h want 008/33",
                     bus.debug_inst_addr, bus.debug_inst_data1);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_data64();
        do_start(7'd0, 7'd64);
        for (int i = 0; i < 64; i++) begin
            send(32'hA000_0000 | i);
            send(32'hB000_0000 | i);
            if (i == 1 || i == 62 || i == 63) begin
                vectors++;
                if (bus.DebugAddress !== DM_ADDRESS'(i * 8) ||
                    bus.DebugData1 !== (32'hA000_0000 | i) ||
                    bus.DebugData2 !== (32'hB000_0000 | i)) begin
                    miscompares++;
                    $display("FAIL data64_pair[%0d]: got %h/%h/%h want %h/%h/%h", i,
                             bus.DebugAddress, bus.DebugData1, bus.DebugData2,
                             DM_ADDRESS'(i * 8), 32'hA000_0000 | i, 32'hB000_0000 | i);
                end
            end
        end
        vectors++;
        if (bus.DebugAddress !== 9'h1F8 || bus.in_ready !== 1'b0 || bus.enable_debug !== 1'b1) begin
            miscompares++;
            $display("FAIL data64_exit: got addr %h rdy %b en %b want 1f8 rdy 0 en 1",
                     bus.DebugAddress, bus.in_ready, bus.enable_debug);
        end
        tick(); tick(); tick();
        vectors++;
        if ({bus.enable_debug, done} !== 2'b01 || bus.debug_inst_addr !== 9'h008) begin
            miscompares++;
            $display("FAIL data64_done: got en/done=%b%b inst_addr %h want 01 008",
                     bus.enable_debug, done, bus.debug_inst_addr);
        end
    endtask

    task automatic test_reset_midload();
        do_start(7'd2, 7'd1);
        send(32'h11);
        send(32'h22);
        send(32'h33);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if ({bus.enable_debug, bus.in_ready, busy, done} !== 4'b0000 ||
            {bus.debug_inst_addr, bus.debug_inst_data1, bus.debug_inst_data2,
             bus.DebugAddress, bus.DebugData1, bus.DebugData2} !== '0) begin
            miscompares++;
            $display("FAIL midreset_clear: got en/rdy/busy/done=%b%b%b%b inst %h/%h/%h data %h/%h/%h want all 0",
                     bus.enable_debug, bus.in_ready, busy, done,
                     bus.debug_inst_addr, bus.debug_inst_data1, bus.debug_inst_data2,
                     bus.DebugAddress, bus.DebugData1, bus.DebugData2);
        end
        send(32'h44);
        send(32'h99);
        vectors++;
        if (bus.in_ready !== 1'b0 || busy !== 1'b0 || bus.debug_inst_data2 !== 32'h0) begin
            miscompares++;
            $display("FAIL midreset_idle: got rdy %b busy %b inst_d2 %h want 0 0 0",
                     bus.in_ready, busy, bus.debug_inst_data2);
        end
        do_start(7'd1, 7'd0);
        send(32'hAA);
        send(32'hBB);
        vectors++;
        if (bus.debug_inst_addr !== 9'h000 || bus.debug_inst_data1 !== 32'hAA ||
            bus.debug_inst_data2 !== 32'hBB || bus.DebugData1 !== 32'h0) begin
            miscompares++;
            $display("FAIL midreset_reload: got inst %h/%h/%h data1 %h want 000/aa/bb data1 0",
                     bus.debug_inst_addr, bus.debug_inst_data1, bus.debug_inst_data2, bus.DebugData1);
        end
        tick(); tick(); tick();
        vectors++;
        if ({bus.enable_debug, done} !== 2'b01) begin
            miscompares++;
            $display("FAIL midreset_done: got en/done=%b%b want 01", bus.enable_debug, done);
        end
    endtask

    task automatic test_start_ignored();
        do_start(7'd2, 7'd1);
        send(32'h11);
        inst_pairs = 7'd0;
        data_pairs = 7'd0;
        start      = 1'b1;
        send(32'h22);
        start      = 1'b0;
        vectors++;
        if (bus.debug_inst_addr !== 9'h000 || bus.debug_inst_data1 !== 32'h11 ||
            bus.debug_inst_data2 !== 32'h22 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ignstart_pair0: got %h/%h/%h rdy %b want 000/11/22 rdy 1",
                     bus.debug_inst_addr, bus.debug_inst_data1, bus.debug_inst_data2, bus.in_ready);
        end
        send(32'h33);
        send(32'h44);
        vectors++;
        if (bus.debug_inst_addr !== 9'h008 || bus.debug_inst_data2 !== 32'h44) begin
            miscompares++;
            $display("FAIL ignstart_pair1: got %h/%h want 008/44",
                     bus.debug_inst_addr, bus.debug_inst_data2);
        end
        send(32'h55);
        send(32'h66);
        vectors++;
        if (bus.DebugAddress !== 9'h000 || bus.DebugData1 !== 32'h55 || bus.DebugData2 !== 32'h66) begin
            miscompares++;
            $display("FAIL ignstart_data: got %h/%h/%h want 000/55/66",
                     bus.DebugAddress, bus.DebugData1, bus.DebugData2);
        end
        tick(); tick(); tick();
        vectors++;
        if ({bus.enable_debug, done} !== 2'b01) begin
            miscompares++;
            $display("FAIL ignstart_done: got en/done=%b%b want 01", bus.enable_debug, done);
        end
    endtask

    task automatic test_start_in_done();
        do_start(7'd1, 7'd0);
        vectors++;
        if ({done, busy, bus.in_ready, bus.enable_debug} !== 4'b0111) begin
            miscompares++;
            $display("FAIL restart_flags: got done/busy/rdy/en=%b%b%b%b want 0111",
                     done, busy, bus.in_ready, bus.enable_debug);
        end
        send(32'hC1);
        send(32'hC2);
        vectors++;
        if (bus.debug_inst_addr !== 9'h000 || bus.debug_inst_data1 !== 32'hC1 ||
            bus.debug_inst_data2 !== 32'hC2) begin
            miscompares++;
            $display("FAIL restart_pair: got %h/%h/%h want 000/c1/c2",
                     bus.debug_inst_addr, bus.debug_inst_data1, bus.debug_inst_data2);
        end
        tick(); tick(); tick();
        vectors++;
        if ({bus.enable_debug, done} !== 2'b01) begin
            miscompares++;
            $display("FAIL restart_done: got en/done=%b%b want 01", bus.enable_debug, done);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_zero_counts();
        test_data64();
        test_reset_midload();
        test_start_ignored();
        test_start_in_done();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
